// File: rtl/addsub_serial_16bit_if.sv
// Request/result bundle for the nibble-serial add/subtract unit.
// The master drives the operands and start; the slave returns status, result and flags.
interface addsub_serial_16bit_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             ovfl;
    logic             cout;
    logic             zero;

    modport master (
        output start, A, B, sub,
        input  busy, done, sum, ovfl, cout, zero
    );

    modport slave (
        input  start, A, B, sub,
        output busy, done, sum, ovfl, cout, zero
    );
endinterface

// File: rtl/addsub_serial_16bit.sv
// WIDTH-bit two's-complement add/subtract computed one nibble per cycle, LSB first,
// with a registered inter-nibble carry and registered sum/ovfl/cout/zero flags.
module addsub_serial_16bit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    addsub_serial_16bit_if.slave bus
);
    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned IW  = $clog2(NIB);
    localparam int unsigned MSB = WIDTH - 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb2_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] sum_q;
    logic [IW-1:0]    idx_q;
    logic [IW+1:0]    bit_ofs;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;
    logic             ovfl_q;
    logic             cout_q;
    logic             zero_q;
    logic [4:0]       nib_d;

    assign bit_ofs = {idx_q, 2'b00};

    // One nibble slice of the ripple adder; res_d is the partial result with this nibble merged in.
    always_comb begin
        nib_d = {1'b0, opa_q[bit_ofs +: 4]} + {1'b0, opb2_q[bit_ofs +: 4]} + {4'b0000, carry_q};
        res_d = res_q;
        res_d[bit_ofs +: 4] = nib_d[3:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            opa_q   <= '0;
            opb2_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovfl_q  <= 1'b0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        // Subtraction as A + ~B + 1: invert B here, inject the +1 as carry-in.
                        opa_q   <= bus.A;
                        opb2_q  <= bus.B ^ {WIDTH{bus.sub}};
                        carry_q <= bus.sub;
                        idx_q   <= '0;
                        res_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    res_q   <= res_d;
                    carry_q <= nib_d[4];
                    if (idx_q == LAST_IDX) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        sum_q   <= res_d;
                        cout_q  <= nib_d[4];
                        zero_q  <= (res_d == '0);
                        ovfl_q  <= (opa_q[MSB] == opb2_q[MSB]) && (res_d[MSB] != opa_q[MSB]);
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.ovfl = ovfl_q;
    assign bus.cout = cout_q;
    assign bus.zero = zero_q;
endmodule

// File: tb/tb_addsub_serial_16bit.sv
// Directed bench for the nibble-serial adder: flag corner cases, cycle-exact handshake,
// ignored restarts and a mid-operation reset abort.
module tb_addsub_serial_16bit;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    addsub_serial_16bit_if #(.WIDTH(16)) bus ();

    addsub_serial_16bit #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation and check every cycle until one past done.
    // poke_run: pulse a conflicting start during RUN; poke_done: pulse one during DONE.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic [15:0] es, input logic eo,
                          input logic ec, input logic ez, input bit poke_run, input bit poke_done);
        logic [15:0] held;
        held      = bus.sum;
        bus.A     = a;
        bus.B     = b;
        bus.sub   = s;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.A     = 16'hFFFF;
        bus.B     = 16'hFFFF;
        bus.sub   = ~s;
        for (int c = 0; c < 4; c++) begin
            check({tag, "_busy"}, 32'(bus.busy), 32'd1);
            check({tag, "_done_early"}, 32'(bus.done), 32'd0);
            check({tag, "_sum_held"}, 32'(bus.sum), 32'(held));
            bus.start = poke_run && (c == 1);
            tick();
        end
        bus.start = 1'b0;
        check({tag, "_done"}, 32'(bus.done), 32'd1);
        check({tag, "_busy_off"}, 32'(bus.busy), 32'd0);
        check({tag, "_sum"}, 32'(bus.sum), 32'(es));
        check({tag, "_ovfl"}, 32'(bus.ovfl), 32'(eo));
        check({tag, "_cout"}, 32'(bus.cout), 32'(ec));
        check({tag, "_zero"}, 32'(bus.zero), 32'(ez));
        bus.start = poke_done;
        tick();
        bus.start = 1'b0;
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
        check({tag, "_sum_hold"}, 32'(bus.sum), 32'(es));
        tick();
        check({tag, "_no_restart"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.sub   = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_flags", {29'd0, bus.ovfl, bus.cout, bus.zero}, 32'd0);
        rst_n = 1'b1;
        tick();

        run_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0 | 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("sub_eq", 16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op("ovf_sub", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op("plain", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("borrow", 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("neg_ovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op("restart", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Abort a subtract mid-flight (carry chain = 1), then confirm a fresh add is clean.
        bus.A     = 16'h0000;
        bus.B     = 16'h0001;
        bus.sub   = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("abort_busy_pre", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_sum", 32'(bus.sum), 32'd0);
        check("abort_flags", {29'd0, bus.ovfl, bus.cout, bus.zero}, 32'd0);
        tick();
        check("abort_idle", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        tick();
        check("abort_stay_idle", {30'd0, bus.busy, bus.done}, 32'd0);
        run_op("post_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
